pcie_pio_completer: RTL and testbench

Generates PCIe completions for 2-DW (64-bit) memory reads addressed to the PIO register space. Sits directly downstream of the PCIe RX parser: consumes its `read_valid`, `address` and `rr_rc_dw2` outputs, queues the requests, and issues each as a single read on the user register bus. Each returned 64-bit word is emitted as a 3DW CplD TLP on the 64-bit AXI stream toward the PCIe core TX port.

---
 rtl/pcie_pio_completer_if.sv | 35 +++
 rtl/pcie_pio_completer.sv | 168 ++++++++++++++++
 tb/tb_pcie_pio_completer.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcie_pio_completer_if.sv
// Signal bundle around the PIO completer: RX-parser read requests, the user register bus
// and the CplD AXI stream toward the PCIe core TX port.
interface pcie_pio_completer_if;
   logic        read_valid;
   logic [12:0] address;
   logic [31:0] rr_rc_dw2;
   logic [15:0] completer_id;

   logic        rd_req;
   logic [12:0] rd_addr;
   logic [63:0] rd_data;
   logic        rd_valid;

   logic        tx_tvalid;
   logic        tx_tready;
   logic        tx_tlast;
   logic [63:0] tx_tdata;
   logic [7:0]  tx_tkeep;

   logic        overflow;

   // Completer side: drives the register bus and the TX stream.
   modport master (
      input  read_valid, address, rr_rc_dw2, completer_id,
      input  rd_data, rd_valid, tx_tready,
      output rd_req, rd_addr, tx_tvalid, tx_tlast, tx_tdata, tx_tkeep, overflow
   );

   // Environment side: RX parser, register file and PCIe core.
   modport slave (
      output read_valid, address, rr_rc_dw2, completer_id,
      output rd_data, rd_valid, tx_tready,
      input  rd_req, rd_addr, tx_tvalid, tx_tlast, tx_tdata, tx_tkeep, overflow
   );
endinterface

// File: rtl/pcie_pio_completer.sv
// Queues 2-DW PIO memory reads, issues one register read at a time and returns each
// 64-bit result as a three-beat 3DW CplD TLP on a 64-bit AXI stream.
module pcie_pio_completer #(
   parameter int DEPTH_LOG2 = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   pcie_pio_completer_if.master   bus
);
   localparam int DEPTH   = 1 << DEPTH_LOG2;
   localparam int ENTRY_W = 45;
   localparam logic [31:0] CPL_DW0 = 32'h4A00_0002;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      BEAT0 = 3'd2,
      BEAT1 = 3'd3,
      BEAT2 = 3'd4
   } state_t;

   state_t state_reg, state_next;

   logic [ENTRY_W-1:0]  fifo_mem [DEPTH];
   logic [DEPTH_LOG2:0] wr_ptr_reg, rd_ptr_reg;
   logic [ENTRY_W-1:0]  fifo_head;
   logic                fifo_empty, fifo_full;
   logic                push, pop, capture, tx_hs;

   logic        rd_req_reg;
   logic [12:0] rd_addr_reg;
   logic [31:0] dw2_reg, p0_reg, p1_reg;
   logic        tx_tvalid_reg, tx_tlast_reg;
   logic [63:0] tx_tdata_reg;
   logic [7:0]  tx_tkeep_reg;
   logic        overflow_reg;

   logic [31:0] p0_swap, p1_swap, dw1;

   // Extra pointer MSB tells a full FIFO from an empty one after wrap-around.
   assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
   assign fifo_full  = (wr_ptr_reg[DEPTH_LOG2] != rd_ptr_reg[DEPTH_LOG2]) &&
                       (wr_ptr_reg[DEPTH_LOG2-1:0] == rd_ptr_reg[DEPTH_LOG2-1:0]);
   assign push       = bus.read_valid && !fifo_full;
   assign fifo_head  = fifo_mem[rd_ptr_reg[DEPTH_LOG2-1:0]];
   assign tx_hs      = tx_tvalid_reg && bus.tx_tready;

   assign dw1 = {bus.completer_id, 3'b000, 1'b0, 12'd8};

   // Undo the RX parser's endian swap on each 32-bit half of the read data.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_bswap
         assign p0_swap[8*gi +: 8] = bus.rd_data[8*(3-gi) +: 8];
         assign p1_swap[8*gi +: 8] = bus.rd_data[32 + 8*(3-gi) +: 8];
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (push) begin
         fifo_mem[wr_ptr_reg[DEPTH_LOG2-1:0]] <= {bus.address, bus.rr_rc_dw2};
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + {{DEPTH_LOG2{1'b0}}, 1'b1};
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + {{DEPTH_LOG2{1'b0}}, 1'b1};
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      pop        = 1'b0;
      capture    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               state_next = READ;
            end
         end
         READ: begin
            if (bus.rd_valid) begin
               capture    = 1'b1;
               state_next = BEAT0;
            end
         end
         BEAT0:   if (tx_hs) state_next = BEAT1;
         BEAT1:   if (tx_hs) state_next = BEAT2;
         BEAT2:   if (tx_hs) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Beats are loaded one handshake ahead so the stream outputs come straight from flops.
   always_ff @(posedge clock) begin
      if (reset) begin
         rd_req_reg    <= 1'b0;
         rd_addr_reg   <= '0;
         dw2_reg       <= '0;
         p0_reg        <= '0;
         p1_reg        <= '0;
         tx_tvalid_reg <= 1'b0;
         tx_tlast_reg  <= 1'b0;
         tx_tdata_reg  <= '0;
         tx_tkeep_reg  <= '0;
         overflow_reg  <= 1'b0;
      end else begin
         rd_req_reg <= pop;
         if (pop) begin
            rd_addr_reg <= fifo_head[44:32];
            dw2_reg     <= fifo_head[31:0];
         end
         if (bus.read_valid && fifo_full) begin
            overflow_reg <= 1'b1;
         end
         if (capture) begin
            p0_reg        <= p0_swap;
            p1_reg        <= p1_swap;
            tx_tvalid_reg <= 1'b1;
            tx_tdata_reg  <= {dw1, CPL_DW0};
            tx_tkeep_reg  <= 8'hFF;
            tx_tlast_reg  <= 1'b0;
         end else if (tx_hs) begin
            case (state_reg)
               BEAT0: begin
                  tx_tdata_reg <= {p0_reg, dw2_reg};
               end
               BEAT1: begin
                  tx_tdata_reg <= {32'h0, p1_reg};
                  tx_tkeep_reg <= 8'h0F;
                  tx_tlast_reg <= 1'b1;
               end
               default: begin
                  tx_tvalid_reg <= 1'b0;
                  tx_tlast_reg  <= 1'b0;
                  tx_tkeep_reg  <= 8'h00;
                  tx_tdata_reg  <= '0;
               end
            endcase
         end
      end
   end

   assign bus.rd_req    = rd_req_reg;
   assign bus.rd_addr   = rd_addr_reg;
   assign bus.tx_tvalid = tx_tvalid_reg;
   assign bus.tx_tlast  = tx_tlast_reg;
   assign bus.tx_tdata  = tx_tdata_reg;
   assign bus.tx_tkeep  = tx_tkeep_reg;
   assign bus.overflow  = overflow_reg;
endmodule

// File: tb/tb_pcie_pio_completer.sv
// Scoreboard bench for pcie_pio_completer: requests push expected TLP beats and read
// addresses; independent monitors pop and compare whenever the DUT presents them.
module tb_pcie_pio_completer;
   localparam logic [15:0] CID = 16'h0300;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   pcie_pio_completer_if bus();

   pcie_pio_completer #(.DEPTH_LOG2(2)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
   } beat_t;

   beat_t       exp_beats [$];
   logic [12:0] exp_addr  [$];
   logic [63:0] regmem    [8192];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   int accepted  = 0;
   int pop_seen  = 0;
   bit model_ovf = 1'b0;

   bit          pending    = 1'b0;
   bit          hold_rd    = 1'b0;
   bit          rand_delay = 1'b0;
   logic [12:0] pending_addr = '0;
   int          resp_delay = 0;

   int tready_mode = 0;
   int hs_count = 0, tlp_count = 0, rdreq_count = 0;
   int last_rdreq_cyc = 0, last_rdvalid_cyc = -100, tlp_start_cyc = 0, tlp_end_cyc = 0;
   int issue_cyc = 0;
   bit prev_stall = 1'b0, prev_tvalid = 1'b0, prev_rdreq = 1'b0;
   beat_t prev_beat;
   logic [63:0] last_tlp [3];
   int beat_idx = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [31:0] bswap(input logic [31:0] x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction

   // Reference completion for one accepted request.
   task automatic push_expect(input logic [12:0] a, input logic [31:0] d2);
      logic [63:0] d;
      beat_t b;
      d = regmem[a];
      exp_addr.push_back(a);
      b.data = {CID, 16'h0008, 32'h4A00_0002}; b.keep = 8'hFF; b.last = 1'b0;
      exp_beats.push_back(b);
      b.data = {bswap(d[31:0]), d2};           b.keep = 8'hFF; b.last = 1'b0;
      exp_beats.push_back(b);
      b.data = {32'h0, bswap(d[63:32])};       b.keep = 8'h0F; b.last = 1'b1;
      exp_beats.push_back(b);
   endtask

   // One parser cycle; acceptance follows the FIFO capacity rule (pops strictly before this edge).
   task automatic drive(input bit v, input logic [12:0] a, input logic [31:0] d2);
      int occ;
      @(posedge clock); #1;
      bus.read_valid = v;
      bus.address    = a;
      bus.rr_rc_dw2  = d2;
      issue_cyc      = cyc;
      if (v) begin
         occ = accepted - pop_seen - (bus.rd_req ? 1 : 0);
         if (occ < 4) begin
            accepted++;
            push_expect(a, d2);
         end else begin
            model_ovf = 1'b1;
         end
      end
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      bit done = 1'b0;
      while (!done && n < budget) begin
         @(negedge clock);
         n++;
         if (exp_beats.size() == 0 && exp_addr.size() == 0 && !pending &&
             !bus.tx_tvalid && !bus.rd_req) done = 1'b1;
      end
      chk(name, done, 1);
   endtask

   task automatic wait_tvalid(input string name, input int budget);
      int n = 0;
      bit seen = 1'b0;
      while (!seen && n < budget) begin
         @(negedge clock);
         n++;
         if (bus.tx_tvalid) seen = 1'b1;
      end
      chk(name, seen, 1);
   endtask

   initial forever begin
      @(posedge clock);
      cyc++;
   end

   // Register-bus responder.
   initial forever begin
      @(posedge clock); #1;
      bus.rd_valid = 1'b0;
      if (pending && !hold_rd && !reset) begin
         if (resp_delay == 0) begin
            bus.rd_valid     = 1'b1;
            bus.rd_data      = regmem[pending_addr];
            pending          = 1'b0;
            last_rdvalid_cyc = cyc;
         end else begin
            resp_delay--;
         end
      end
   end

   initial forever begin
      @(posedge clock); #1;
      if (tready_mode == 0) bus.tx_tready = 1'b1;
      else if (tready_mode == 2) bus.tx_tready = ($urandom_range(0, 1) == 1);
   end

   // Monitor: TX stream scoreboard, hold-stability and register-bus request checks.
   initial forever begin
      beat_t e, cur;
      @(negedge clock);
      if (!reset) begin
         cur.data = bus.tx_tdata; cur.keep = bus.tx_tkeep; cur.last = bus.tx_tlast;
         if (prev_stall) begin
            chk("hold_tvalid", bus.tx_tvalid, 1);
            chk("hold_tdata", cur.data, prev_beat.data);
            chk("hold_tkeep", cur.keep, prev_beat.keep);
            chk("hold_tlast", cur.last, prev_beat.last);
         end
         if (bus.tx_tvalid && !prev_tvalid) tlp_start_cyc = cyc;
         if (bus.tx_tvalid && bus.tx_tready) begin
            hs_count++;
            if (exp_beats.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_beat: got 0x%0h, required no beat", cur.data);
            end else begin
               e = exp_beats.pop_front();
               chk("tdata", cur.data, e.data);
               chk("tkeep", cur.keep, e.keep);
               chk("tlast", cur.last, e.last);
            end
            if (beat_idx < 3) last_tlp[beat_idx] = cur.data;
            beat_idx++;
            if (cur.last) begin
               tlp_count++;
               tlp_end_cyc = cyc;
               beat_idx = 0;
            end
         end
         prev_stall  = bus.tx_tvalid && !bus.tx_tready;
         prev_tvalid = bus.tx_tvalid;
         prev_beat   = cur;
         if (bus.rd_req) begin
            rdreq_count++;
            pop_seen++;
            last_rdreq_cyc = cyc;
            chk("rd_req_single_pulse", prev_rdreq, 0);
            chk("rd_outstanding", pending, 0);
            chk("rd_req_spacing", (cyc - last_rdvalid_cyc >= 5), 1);
            if (exp_addr.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_rd_req: got addr 0x%0h, required no request", bus.rd_addr);
            end else begin
               chk("rd_addr", bus.rd_addr, exp_addr.pop_front());
            end
            pending      = 1'b1;
            pending_addr = bus.rd_addr;
            resp_delay   = rand_delay ? $urandom_range(0, 2) : 0;
         end
         prev_rdreq = bus.rd_req;
      end else begin
         prev_stall  = 1'b0;
         prev_tvalid = 1'b0;
         prev_rdreq  = 1'b0;
         beat_idx    = 0;
      end
   end

   initial begin
      #2000000;
      n_fail++;
      $display("FAIL watchdog: got timeout, required completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      int hs0, t0, r0;
      bus.read_valid   = 1'b0;
      bus.address      = '0;
      bus.rr_rc_dw2    = '0;
      bus.completer_id = CID;
      bus.rd_data      = '0;
      bus.rd_valid     = 1'b0;
      bus.tx_tready    = 1'b1;
      for (int i = 0; i < 8192; i++) regmem[i] = {$urandom, $urandom};

      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("reset_rd_req", bus.rd_req, 0);
      chk("reset_rd_addr", bus.rd_addr, 0);
      chk("reset_tvalid", bus.tx_tvalid, 0);
      chk("reset_tlast", bus.tx_tlast, 0);
      chk("reset_tdata", bus.tx_tdata, 0);
      chk("reset_tkeep", bus.tx_tkeep, 0);
      chk("reset_overflow", bus.overflow, 0);
      @(posedge clock); #1;
      reset = 1'b0;

      // Single read with the reference values.
      regmem[16] = 64'h1122_3344_5566_7788;
      drive(1'b1, 13'h0010, 32'h0100_2A08);
      t0 = issue_cyc;
      drive(1'b0, 13'h0, 32'h0);
      wait_idle("single_done", 200);
      chk("single_rd_latency", last_rdreq_cyc - t0, 2);
      chk("single_cpl_latency", tlp_start_cyc - last_rdvalid_cyc, 1);
      chk("single_tlp_span", tlp_end_cyc - tlp_start_cyc, 2);
      chk("single_rd_addr", bus.rd_addr, 13'h0010);
      chk("single_beat0", last_tlp[0], 64'h0300_0008_4A00_0002);
      chk("single_beat1", last_tlp[1], 64'h8877_6655_0100_2A08);
      chk("single_beat2", last_tlp[2], 64'h0000_0000_4433_2211);

      // Backpressure with tready 1,0,0,1,0,1.
      tready_mode = 1;
      bus.tx_tready = 1'b0;
      hs0 = hs_count; t0 = tlp_count;
      drive(1'b1, 13'h0010, 32'h0100_2A08);
      drive(1'b0, 13'h0, 32'h0);
      wait_tvalid("bp_tvalid_seen", 100);
      for (int i = 0; i < 6; i++) begin
         @(posedge clock); #1;
         bus.tx_tready = pat[i];
      end
      tready_mode = 0;
      wait_idle("bp_done", 200);
      chk("bp_handshakes", hs_count - hs0, 3);
      chk("bp_tlps", tlp_count - t0, 1);

      // Burst of four back-to-back requests.
      t0 = tlp_count; r0 = rdreq_count;
      for (int i = 0; i < 4; i++) drive(1'b1, 13'($urandom), $urandom);
      drive(1'b0, 13'h0, 32'h0);
      wait_idle("burst_done", 400);
      chk("burst_tlps", tlp_count - t0, 4);
      chk("burst_rd_reqs", rdreq_count - r0, 4);
      chk("burst_overflow", bus.overflow, 0);

      // Overflow: six strobes with the register bus stalled.
      rand_delay = 1'b1;
      hold_rd = 1'b1;
      t0 = tlp_count;
      for (int i = 0; i < 6; i++) drive(1'b1, 13'($urandom), $urandom);
      drive(1'b0, 13'h0, 32'h0);
      repeat (5) @(posedge clock);
      hold_rd = 1'b0;
      wait_idle("ovf_done", 600);
      chk("ovf_flag", bus.overflow, 1);
      chk("ovf_model", model_ovf, 1);
      chk("ovf_tlps", tlp_count - t0, 5);

      // Reset during BEAT1 with two requests still queued.
      rand_delay = 1'b0;
      tready_mode = 1;
      bus.tx_tready = 1'b0;
      for (int i = 0; i < 3; i++) drive(1'b1, 13'($urandom), $urandom);
      drive(1'b0, 13'h0, 32'h0);
      wait_tvalid("rst_tvalid_seen", 100);
      @(posedge clock); #1;
      bus.tx_tready = 1'b1;
      @(posedge clock); #1;
      bus.tx_tready = 1'b0;
      @(negedge clock);
      chk("rst_pre_tvalid", bus.tx_tvalid, 1);
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      exp_beats.delete();
      exp_addr.delete();
      accepted = 0; pop_seen = 0; model_ovf = 1'b0; pending = 1'b0;
      last_rdvalid_cyc = -100;
      r0 = rdreq_count;
      @(negedge clock);
      chk("rst_abort_tvalid", bus.tx_tvalid, 0);
      chk("rst_overflow", bus.overflow, 0);
      repeat (10) @(negedge clock);
      chk("rst_no_rd_req", rdreq_count - r0, 0);
      tready_mode = 0;
      t0 = tlp_count;
      drive(1'b1, 13'h1ABC, 32'hCAFE_0010);
      drive(1'b0, 13'h0, 32'h0);
      wait_idle("rst_fresh_done", 200);
      chk("rst_fresh_tlps", tlp_count - t0, 1);

      // Randomized traffic with random backpressure and read latency.
      rand_delay = 1'b1;
      tready_mode = 2;
      for (int i = 0; i < 80; i++) begin
         drive(($urandom_range(0, 2) == 0), 13'($urandom), $urandom);
      end
      drive(1'b0, 13'h0, 32'h0);
      tready_mode = 0;
      wait_idle("rand_done", 3000);
      chk("rand_overflow", bus.overflow, model_ovf);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
